reflet_vga_scanout: RTL

Read-side engine for the VGA framebuffer. It generates VGA horizontal/vertical timing and walks the framebuffer in raster order, driving the read port of `reflet_ram_dual_port`. It registers the returned pixel data and aligns it with hsync, vsync and blank so the pad outputs are mutually consistent. Each framebuffer pixel is upscaled by an integer factor in both directions. The CPU-side writer owns the write port of the same RAM.

---
 rtl/reflet_vga_scanout.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/reflet_vga_scanout.sv
// rtl/reflet_vga_scanout.sv - VGA timing generator and upscaling framebuffer read engine
module reflet_vga_scanout #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter int SYNC_POL  = 0,
    parameter int FB_WIDTH  = 80,
    parameter int SCALE     = 8,
    parameter int addrSize  = 13,
    parameter int depth     = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic                pixel_tick,
    output logic [addrSize-1:0] addr_read,
    output logic                ram_enable,
    input  logic [depth-1:0]    data_out,
    output logic [depth-1:0]    color,
    output logic                hsync,
    output logic                vsync,
    output logic                blank,
    output logic                frame_start
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_VIS  = 11'(H_VISIBLE);
    localparam logic [10:0] V_VIS  = 11'(V_VISIBLE);
    localparam logic [10:0] HS_BEG = 11'(H_VISIBLE + H_FRONT);
    localparam logic [10:0] HS_END = 11'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [10:0] VS_BEG = 11'(V_VISIBLE + V_FRONT);
    localparam logic [10:0] VS_END = 11'(V_VISIBLE + V_FRONT + V_SYNC);
    localparam int SW = (SCALE > 1) ? $clog2(SCALE) : 1;
    localparam logic [SW-1:0] S_LAST = SW'(SCALE - 1);
    localparam logic [addrSize-1:0] FB_STEP = addrSize'(FB_WIDTH);
    localparam logic SYNC_ON = (SYNC_POL != 0);

    logic [10:0]          h, v;
    logic [SW-1:0]        xs, ys;
    logic [addrSize-1:0]  xf, row_base, addr_hold;
    logic                 visible, line_end, hs_now, vs_now, first_now;
    logic                 tick_d;
    logic [depth-1:0]     data_hold, pix;
    logic                 s1_blank, s1_hs, s1_vs, s1_first;

    assign visible   = (h < H_VIS) && (v < V_VIS);
    assign line_end  = (h == H_LAST);
    assign hs_now    = (h >= HS_BEG) && (h < HS_END);
    assign vs_now    = (v >= VS_BEG) && (v < VS_END);
    assign first_now = (h == 11'd0) && (v == 11'd0);

    // Address is live while visible and frozen at its last value during blanking.
    assign addr_read  = visible ? (row_base + xf) : addr_hold;
    assign ram_enable = visible & enable & reset;

    // The RAM word for the previous position is ready one clk after a tick;
    // capture it then so slow tick rates see the same pixel as back-to-back ticks.
    assign pix = tick_d ? data_out : data_hold;

    // Raster counters plus multiplier-free framebuffer address walk.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            h        <= '0;
            v        <= '0;
            xs       <= '0;
            ys       <= '0;
            xf       <= '0;
            row_base <= '0;
        end else if (!enable) begin
            h        <= '0;
            v        <= '0;
            xs       <= '0;
            ys       <= '0;
            xf       <= '0;
            row_base <= '0;
        end else if (pixel_tick) begin
            if (line_end) begin
                h  <= '0;
                xs <= '0;
                xf <= '0;
                if (v == V_LAST) begin
                    v        <= '0;
                    ys       <= '0;
                    row_base <= '0;
                end else begin
                    v <= v + 11'd1;
                    if (v < V_VIS) begin
                        if (ys == S_LAST) begin
                            ys       <= '0;
                            row_base <= row_base + FB_STEP;
                        end else begin
                            ys <= ys + 1'b1;
                        end
                    end
                end
            end else begin
                h <= h + 11'd1;
                if (visible) begin
                    if (xs == S_LAST) begin
                        xs <= '0;
                        xf <= xf + 1'b1;
                    end else begin
                        xs <= xs + 1'b1;
                    end
                end
            end
        end
    end

    // Remember the last driven address so it can be held through blanking.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) addr_hold <= '0;
        else        addr_hold <= addr_read;
    end

    // Capture RAM data one clk after each tick.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tick_d    <= 1'b0;
            data_hold <= '0;
        end else begin
            tick_d <= pixel_tick;
            if (tick_d) data_hold <= data_out;
        end
    end

    // Two-stage sync/blank/first-pixel pipeline aligned with registered color.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_blank    <= 1'b1;
            s1_hs       <= 1'b0;
            s1_vs       <= 1'b0;
            s1_first    <= 1'b0;
            blank       <= 1'b1;
            hsync       <= ~SYNC_ON;
            vsync       <= ~SYNC_ON;
            color       <= '0;
            frame_start <= 1'b0;
        end else if (!enable) begin
            s1_blank    <= 1'b1;
            s1_hs       <= 1'b0;
            s1_vs       <= 1'b0;
            s1_first    <= 1'b0;
            blank       <= 1'b1;
            hsync       <= ~SYNC_ON;
            vsync       <= ~SYNC_ON;
            color       <= '0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= pixel_tick & s1_first;
            if (pixel_tick) begin
                s1_blank <= ~visible;
                s1_hs    <= hs_now;
                s1_vs    <= vs_now;
                s1_first <= first_now;
                blank    <= s1_blank;
                hsync    <= s1_hs ? SYNC_ON : ~SYNC_ON;
                vsync    <= s1_vs ? SYNC_ON : ~SYNC_ON;
                color    <= s1_blank ? '0 : pix;
            end
        end
    end

endmodule
